// File: rtl/rca_pkg.sv
// Shared types and sizing helpers for the multi-cycle ripple-carry adder.
package rca_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of chunk cycles needed to cover the full operand width.
    function automatic int unsigned chunk_count(int unsigned width, int unsigned chunk);
        return width / chunk;
    endfunction

    // Chunk index register width; kept at least one bit wide for a single-chunk build.
    function automatic int unsigned idx_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple of full adders; the reused slice of the adder.
module rca_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);

    logic c;

    // Ripple the carry LSB to MSB through one full adder per bit.
    always_comb begin
        sum = '0;
        c   = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/rca_multicycle_adder.sv
// Multi-cycle ripple-carry adder: WIDTH-bit add, CHUNK bits per clock, started
// by a rising edge on enable. Optional subtract mode is enabled by defining
// RCA_SUB_EN; otherwise the sub input is ignored.
module rca_multicycle_adder
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH:0]   q,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N     = chunk_count(WIDTH, CHUNK);
    localparam int unsigned IDX_W = idx_width(N);

    state_t             state_q, state_d;
    logic               enable_q;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [WIDTH:0]     q_q, q_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   b_eff;
    logic               cin_eff;
    logic               start;
    logic               last;
    logic [CHUNK-1:0]   slice_sum;
    logic               slice_cout;

`ifdef RCA_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = cin ^ sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign cin_eff    = cin;
`endif

    assign busy  = (state_q == RUN);
    assign start = enable & ~enable_q & ~busy;
    assign last  = (idx_q == IDX_W'(N - 1));

    rca_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .a    (a_q[idx_q*CHUNK +: CHUNK]),
        .b    (b_q[idx_q*CHUNK +: CHUNK]),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    // Next-state and datapath: latch operands on start, accumulate one chunk per RUN cycle.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        q_d     = q_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    idx_d   = '0;
                    sum_d   = '0;
                end
            end
            RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = slice_sum;
                carry_d = slice_cout;
                idx_d   = idx_q + 1'b1;
                if (last) begin
                    // sum_d already holds the final chunk, so q and overflow see the full sum.
                    q_d     = {slice_cout, sum_d};
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) & (slice_sum[CHUNK-1] != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            enable_q <= 1'b0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            sum_q    <= '0;
            q_q      <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            enable_q <= enable;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sum_q    <= sum_d;
            q_q      <= q_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign q        = q_q;
    assign overflow = ovf_q;
    assign done     = done_q;

endmodule

// File: tb/tb_rca_multicycle_adder.sv
// Directed self-checking bench for rca_multicycle_adder at WIDTH=16, CHUNK=4.
module tb_rca_multicycle_adder;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             enable;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic [WIDTH:0]   q;
    logic             overflow;
    logic             busy;
    logic             done;

    int errors = 0;
    int checks = 0;

    rca_multicycle_adder #(
        .WIDTH(16),
        .CHUNK(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .sub      (sub),
        .q        (q),
        .overflow (overflow),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [WIDTH:0] obs, input logic [WIDTH:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation from a fresh enable edge; operands are scrambled while busy.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic ci, input logic sb,
                         input logic [WIDTH:0] exp_q, input logic exp_ovf);
        a      = av;
        b      = bv;
        cin    = ci;
        sub    = sb;
        enable = 1'b1;
        step();
        check({tag, " busy@start"}, {16'h0, busy}, 17'h1);
        check({tag, " done@start"}, {16'h0, done}, 17'h0);
        enable = 1'b0;
        a      = WIDTH'($urandom);
        b      = WIDTH'($urandom);
        cin    = ~ci;
        sub    = ~sb;
        for (int i = 0; i < 3; i++) begin
            step();
            check({tag, " busy@run"}, {16'h0, busy}, 17'h1);
            check({tag, " done@run"}, {16'h0, done}, 17'h0);
        end
        step();
        check({tag, " done"}, {16'h0, done}, 17'h1);
        check({tag, " busy@done"}, {16'h0, busy}, 17'h0);
        check({tag, " q"}, q, exp_q);
        check({tag, " ovf"}, {16'h0, overflow}, {16'h0, exp_ovf});
        step();
        check({tag, " done@after"}, {16'h0, done}, 17'h0);
        check({tag, " q@hold"}, q, exp_q);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        sub    = 1'b0;

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            a      = WIDTH'($urandom);
            b      = WIDTH'($urandom);
            cin    = 1'($urandom);
            sub    = 1'($urandom);
            enable = 1'($urandom);
            step();
        end
        check("rst q", q, 17'h0);
        check("rst ovf", {16'h0, overflow}, 17'h0);
        check("rst busy", {16'h0, busy}, 17'h0);
        check("rst done", {16'h0, done}, 17'h0);

        // Release with enable already high counts as a start.
        rst_n = 1'b1;
        do_op("relstart", 16'h0003, 16'h0004, 1'b0, 1'b0, 17'h00007, 1'b0);

        do_op("add1_5",   16'h0001, 16'h0005, 1'b0, 1'b0, 17'h00006, 1'b0);
        do_op("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0);
        do_op("posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1);
        do_op("negovf",   16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1);
        do_op("cin",      16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 1'b0);

        // Enable edges while busy are ignored; held-high enable does not restart.
        a      = 16'h000C;
        b      = 16'h0004;
        cin    = 1'b0;
        sub    = 1'b0;
        enable = 1'b1;
        step();
        check("ign busy@start", {16'h0, busy}, 17'h1);
        a      = 16'h1111;
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        check("ign done@T2", {16'h0, done}, 17'h0);
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        check("ign done", {16'h0, done}, 17'h1);
        check("ign q", q, 17'h00010);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ign norestart busy", {16'h0, busy}, 17'h0);
            check("ign norestart done", {16'h0, done}, 17'h0);
        end
        enable = 1'b0;
        step();

`ifdef RCA_SUB_EN
        do_op("sub5_7",   16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE, 1'b0);
        do_op("sub7_5",   16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002, 1'b0);
        do_op("subovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1);
`else
        do_op("sub5_7",   16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0000C, 1'b0);
        do_op("sub7_5",   16'h0007, 16'h0005, 1'b0, 1'b1, 17'h0000C, 1'b0);
        do_op("subovf",   16'h8000, 16'h0001, 1'b0, 1'b1, 17'h08001, 1'b0);
`endif

        // Reset during RUN aborts without a done pulse.
        a      = 16'h0101;
        b      = 16'h0101;
        cin    = 1'b0;
        sub    = 1'b0;
        enable = 1'b1;
        step();
        enable = 1'b0;
        step();
        step();
        check("abort busy@run", {16'h0, busy}, 17'h1);
        rst_n = 1'b0;
        step();
        check("abort busy", {16'h0, busy}, 17'h0);
        check("abort done", {16'h0, done}, 17'h0);
        check("abort q", q, 17'h0);
        check("abort ovf", {16'h0, overflow}, 17'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("abort nodone", {16'h0, done}, 17'h0);
        end

        do_op("postrst",  16'h00FF, 16'h0F01, 1'b0, 1'b0, 17'h01000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
